// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator voice: mode encodings and default widths.
package tone_pkg;

  localparam int unsigned TONE_WIDTH_DEF = 8;
  localparam int unsigned TONE_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_MUTE   = 2'd3
  } tone_mode_e;

endpackage

// File: rtl/tone_prescaler.sv
// Clock prescaler: counts up to a terminal value, then reloads to zero.
// reload_o is the same-cycle terminal strobe; tick_o is its registered copy.
module tone_prescaler
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W = TONE_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o,
  output logic             reload_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    reload_o = enable_i && (cnt_q == period_i);
    cnt_d    = cnt_q + 1'b1;
    tick_d   = reload_o;
    if (!enable_i || reload_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tone_generator.sv
// Single-voice tone generator: prescaled phase accumulator shaped into square,
// sawtooth or triangle samples. Settings are only retaken at a waveform wrap.
module tone_generator
  import tone_pkg::*;
#(
  parameter int unsigned WIDTH = TONE_WIDTH_DEF,
  parameter int unsigned CNT_W = TONE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] wave_out,
  output logic             tick,
  output logic             wrap
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  tone_mode_e       mode_q, mode_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             wrap_q, wrap_d;
  logic             reload;

  tone_prescaler #(
    .CNT_W(CNT_W)
  ) u_prescaler (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (enable),
    .period_i (period_q),
    .tick_o   (tick),
    .reload_o (reload)
  );

  function automatic logic [WIDTH-1:0] shape(
    input logic [WIDTH-1:0] ph,
    input tone_mode_e       m,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] s;
    s     = {ph[WIDTH-2:0], 1'b0};
    shape = '0;
    case (m)
      MODE_SQUARE: shape = (ph < d) ? {WIDTH{1'b1}} : '0;
      MODE_SAW:    shape = ph;
      // Rising half doubles the phase; falling half mirrors it via inversion.
      MODE_TRI:    shape = ph[WIDTH-1] ? ~s : s;
      MODE_MUTE:   shape = '0;
      default:     shape = '0;
    endcase
    return shape;
  endfunction

  always_comb begin
    period_d = period_q;
    duty_d   = duty_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    wave_d   = wave_q;
    wrap_d   = 1'b0;
    if (!enable) begin
      phase_d  = '0;
      wave_d   = '0;
      period_d = period;
      duty_d   = duty;
      mode_d   = tone_mode_e'(mode);
    end else begin
      wave_d = shape(phase_q, mode_q, duty_q);
      if (reload) begin
        phase_d = phase_q + 1'b1;
        if (phase_q == {WIDTH{1'b1}}) begin
          wrap_d   = 1'b1;
          period_d = period;
          duty_d   = duty;
          mode_d   = tone_mode_e'(mode);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      duty_q   <= '0;
      mode_q   <= MODE_SQUARE;
      phase_q  <= '0;
      wave_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      duty_q   <= duty_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      wave_q   <= wave_d;
      wrap_q   <= wrap_d;
    end
  end

  assign wave_out = wave_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator (WIDTH=8, CNT_W=16).
module tb_tone_generator;
  import tone_pkg::*;

  localparam int W    = 8;
  localparam int FULL = 1 << W;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [7:0]  duty;
  logic [7:0]  wave_out;
  logic        tick;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  tone_generator #(.WIDTH(8), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .period   (period),
    .duty     (duty),
    .wave_out (wave_out),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Reference: each waveform cycle is a segment of (P+1)*2^W clocks with fixed
  // settings; within it, clock t shows shape(floor(t/(P+1))).
  function automatic int ref_shape(int ph, int md, int dt);
    case (md)
      0:       return (ph < dt) ? FULL - 1 : 0;
      1:       return ph;
      2:       return (ph < FULL / 2) ? 2 * ph : (FULL - 1) - 2 * (ph - FULL / 2);
      default: return 0;
    endcase
  endfunction

  int m_wave, m_tick, m_wrap;
  int m_per, m_duty, m_mode, m_t;
  bit model_on = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_wave = 0; m_tick = 0; m_wrap = 0;
      m_per = 0; m_duty = 0; m_mode = 0; m_t = 0;
      model_on = 1'b1;
    end else if (!enable) begin
      m_wave = 0; m_tick = 0; m_wrap = 0;
      m_per = int'(period); m_duty = int'(duty); m_mode = int'(mode); m_t = 0;
    end else begin
      m_wave = ref_shape((m_t / (m_per + 1)) % FULL, m_mode, m_duty);
      m_tick = ((m_t % (m_per + 1)) == m_per) ? 1 : 0;
      m_wrap = (m_t == (m_per + 1) * FULL - 1) ? 1 : 0;
      if (m_wrap == 1) begin
        m_per = int'(period); m_duty = int'(duty); m_mode = int'(mode); m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (model_on) begin
      chk("model_wave", int'(wave_out), m_wave);
      chk("model_tick", int'(tick), m_tick);
      chk("model_wrap", int'(wrap), m_wrap);
    end
  endtask

  task automatic start(input logic [1:0] md, input int per, input int dt);
    reset  = 1'b1;
    enable = 1'b0;
    mode   = md;
    period = 16'(per);
    duty   = 8'(dt);
    step();
    reset = 1'b0;
    step();
    enable = 1'b1;
  endtask

  typedef struct {
    logic [1:0] md;
    int         per;
    int         dt;
    int         n;
    int         wave;
    int         tk;
    int         wr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int  cnt, n2, hi, tk;
    bit  done;

    vecs.push_back('{MODE_SAW,    0,   0,    1,   0, 1, 0});
    vecs.push_back('{MODE_SAW,    0,   0,   11,  10, 1, 0});
    vecs.push_back('{MODE_SAW,    0,   0,  256, 255, 1, 1});
    vecs.push_back('{MODE_SAW,    0,   0,  257,   0, 1, 0});
    vecs.push_back('{MODE_SAW,    2,   0,    9,   2, 1, 0});
    vecs.push_back('{MODE_TRI,    0,   0,    2,   2, 1, 0});
    vecs.push_back('{MODE_TRI,    0,   0,  128, 254, 1, 0});
    vecs.push_back('{MODE_TRI,    0,   0,  129, 255, 1, 0});
    vecs.push_back('{MODE_TRI,    0,   0,  130, 253, 1, 0});
    vecs.push_back('{MODE_TRI,    0,   0,  256,   1, 1, 1});
    vecs.push_back('{MODE_SQUARE, 0,  64,   64, 255, 1, 0});
    vecs.push_back('{MODE_SQUARE, 0,  64,   65,   0, 1, 0});
    vecs.push_back('{MODE_SQUARE, 0,   0,    1,   0, 1, 0});
    vecs.push_back('{MODE_SQUARE, 0, 255,  255, 255, 1, 0});
    vecs.push_back('{MODE_SQUARE, 0, 255,  256,   0, 1, 1});
    vecs.push_back('{MODE_SQUARE, 3,  64,  256, 255, 1, 0});
    vecs.push_back('{MODE_SQUARE, 3,  64,  257,   0, 0, 0});
    vecs.push_back('{MODE_SQUARE, 3,  64, 1024,   0, 1, 1});
    vecs.push_back('{MODE_MUTE,   2,   0,   50,   0, 0, 0});
    vecs.push_back('{MODE_MUTE,   0,   0,  256,   0, 1, 1});

    // Reset held with enable high
    reset = 1'b1; enable = 1'b1; mode = MODE_SAW; period = 16'd0; duty = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_wave", int'(wave_out), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_wrap", int'(wrap), 0);
    end
    reset = 1'b0;
    chk("rst_rel_wave", int'(wave_out), 0);
    chk("rst_rel_tick", int'(tick), 0);

    foreach (vecs[k]) begin
      start(vecs[k].md, vecs[k].per, vecs[k].dt);
      for (int i = 0; i < vecs[k].n; i++) step();
      chk($sformatf("vec%0d_wave", k), int'(wave_out), vecs[k].wave);
      chk($sformatf("vec%0d_tick", k), int'(tick), vecs[k].tk);
      chk($sformatf("vec%0d_wrap", k), int'(wrap), vecs[k].wr);
    end

    // Retune mid-cycle: old timing holds until the wrap
    start(MODE_SQUARE, 1, 32);
    for (int i = 0; i < 201; i++) step();
    period = 16'd5; duty = 8'd128;
    cnt = 201; done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step(); cnt++;
      if (wrap) done = 1'b1;
    end
    chk("retune_first_wrap", cnt, 512);
    n2 = 0; hi = 0; tk = 0; done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step(); n2++;
      if (wave_out == 8'hFF) hi++;
      if (tick) tk++;
      if (wrap) done = 1'b1;
    end
    chk("retune_seg_len", n2, 1536);
    chk("retune_high", hi, 768);
    chk("retune_ticks", tk, 256);

    // Drop enable at phase 50, then re-enable
    start(MODE_SAW, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (wave_out == 8'd50) done = 1'b1;
    end
    chk("reach_phase50", int'(done), 1);
    enable = 1'b0;
    step();
    chk("drop_wave", int'(wave_out), 0);
    chk("drop_tick", int'(tick), 0);
    enable = 1'b1;
    step();
    chk("reen_wave0", int'(wave_out), 0);
    step();
    chk("reen_wave1", int'(wave_out), 1);

    // Reset during a tick cycle
    for (int i = 0; i < 20; i++) step();
    chk("pre_rst_tick", int'(tick), 1);
    reset = 1'b1;
    step();
    chk("tickrst_wave", int'(wave_out), 0);
    chk("tickrst_tick", int'(tick), 0);
    chk("tickrst_wrap", int'(wrap), 0);
    reset = 1'b0;

    // Randomized traffic against the segment model
    for (int i = 0; i < 40000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      reset = ($urandom_range(0, 2999) == 0);
      if (r < 2) enable = ~enable;
      if (r < 12) begin
        mode   = 2'($urandom_range(0, 3));
        period = 16'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       duty = 8'd0;
          1:       duty = 8'd255;
          default: duty = 8'($urandom_range(0, 255));
        endcase
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
